// File: rtl/lcd_pkg.sv
// Shared state encoding and LCD command constants for the LCD command arbiter.
package lcd_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, SETTLE} lcd_state_t;

    localparam int         RS_BIT    = 8;
    localparam logic [8:0] LCD_CLEAR = 9'h001;
    localparam logic [8:0] LCD_HOME  = 9'h002;
    localparam logic [8:0] LCD_LINE2 = 9'h0C0;

    // Clear and both home encodings (0x02/0x03) need the long settle time.
    function automatic logic is_long_cmd(input logic [8:0] word);
        return !word[RS_BIT] &&
               ((word[7:0] == LCD_CLEAR[7:0]) ||
                (word[7:0] == LCD_HOME[7:0])  ||
                (word[7:0] == (LCD_HOME[7:0] | LCD_CLEAR[7:0])));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: search starts at the pointer, pointer moves past each accepted winner.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [NREQ-1:0]  iReq,
    input  logic             iAdvance,
    output logic [NREQ-1:0]  oGrant,
    output logic [IDX_W-1:0] oIdx,
    output logic             oValid
);

    localparam int SW = IDX_W + 1;

    logic [IDX_W-1:0] ptr_q;
    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every output and temporary gets a default before the search so no path infers a latch.
    always_comb begin
        oGrant = '0;
        oIdx   = '0;
        oValid = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            cand = sum[IDX_W-1:0];
            if (!oValid && iReq[cand]) begin
                oValid       = 1'b1;
                oIdx         = cand;
                oGrant[cand] = 1'b1;
            end
        end
    end

    // NOTE: reset is synchronous -- iRST only takes effect on a rising iCLK.
    // NOTE: clocked state uses <= so every register updates from pre-edge values.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ptr_q <= '0;
        end else if (iAdvance) begin
            ptr_q <= (oIdx == IDX_W'(NREQ - 1)) ? '0 : oIdx + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Shares the LCD_Core command port among NREQ requesters; owns the start/done handshake and settle delay.
module lcd_cmd_arbiter
    import lcd_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int DLY_W     = 20,
    parameter int DLY_SHORT = 262142,
    parameter int DLY_LONG  = 800000,
    parameter int DONE_TMO  = 1023
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [NREQ-1:0]   iReq,
    input  logic [NREQ-1:0]   iLock,
    input  logic [9*NREQ-1:0] iCmd,
    output logic [NREQ-1:0]   oAck,
    output logic [NREQ-1:0]   oGrant,
    output logic              oBusy,
    output logic              oErr,
    output logic [7:0]        oLCD_DATA,
    output logic              oLCD_RS,
    output logic              oLCD_Start,
    input  logic              iLCD_Done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    lcd_state_t       state, state_nxt;
    logic             lock_q;
    logic [IDX_W-1:0] owner_q;
    logic [NREQ-1:0]  req_elig, win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid, take;
    logic [8:0]       win_cmd;
    logic [DLY_W-1:0] tmo_cnt, settle_cnt;
    logic             done_hit, tmo_hit, settle_end;

    // A held lock hides everyone but the owner, so an idle owner stalls the port.
    always_comb begin
        req_elig = iReq;
        if (lock_q) begin
            req_elig = iReq & (NREQ'(1) << owner_q);
        end
    end

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iReq     (req_elig),
        .iAdvance (take),
        .oGrant   (win_oh),
        .oIdx     (win_idx),
        .oValid   (win_valid)
    );

    always_comb begin
        win_cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_cmd = iCmd[9*i +: 9];
            end
        end
    end

    assign take       = (state == IDLE) && win_valid;
    assign done_hit   = (state == WAIT_DONE) && iLCD_Done;
    // Done in the final wait cycle still counts as success.
    assign tmo_hit    = (state == WAIT_DONE) && !iLCD_Done && (tmo_cnt == DLY_W'(DONE_TMO - 1));
    assign settle_end = (state == SETTLE) && (settle_cnt == '0);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (take) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_DONE;
            WAIT_DONE: if (done_hit) state_nxt = SETTLE;
                       else if (tmo_hit) state_nxt = IDLE;
            SETTLE:    if (settle_end) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        oLCD_Start = (state == ISSUE) || (state == WAIT_DONE);
        oBusy      = (state != IDLE);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oAck       <= '0;
            oGrant     <= '0;
            oErr       <= 1'b0;
            oLCD_RS    <= 1'b0;
            oLCD_DATA  <= '0;
            lock_q     <= 1'b0;
            owner_q    <= '0;
            tmo_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            oAck <= '0;
            oErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        oAck                   <= win_oh;
                        oGrant                 <= win_oh;
                        {oLCD_RS, oLCD_DATA}   <= win_cmd;
                        lock_q                 <= iLock[win_idx];
                        owner_q                <= win_idx;
                    end
                end
                ISSUE: tmo_cnt <= '0;
                WAIT_DONE: begin
                    if (done_hit) begin
                        // Loaded with length-1 so SETTLE lasts exactly the settle count.
                        settle_cnt <= is_long_cmd({oLCD_RS, oLCD_DATA}) ? DLY_W'(DLY_LONG - 1)
                                                                         : DLY_W'(DLY_SHORT - 1);
                    end else if (tmo_hit) begin
                        oErr   <= 1'b1;
                        lock_q <= 1'b0;
                        oGrant <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_end) begin
                        if (!lock_q) oGrant <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Randomised scoreboard bench for lcd_cmd_arbiter with an LCD_Core done-latency model.
module tb_lcd_cmd_arbiter;

    localparam int NREQ      = 3;
    localparam int DLY_SHORT = 8;
    localparam int DLY_LONG  = 32;
    localparam int DONE_TMO  = 16;

    typedef struct packed {
        logic [8:0] cmd;
        logic       lock;
        int         lat;     // Done latency in cycles after Start; -1 = never
    } word_t;

    typedef struct packed {
        int         idx;
        logic [8:0] cmd;
        logic       err;
        int         lat;
        int         settle;
        logic       lock_after;
    } exp_t;

    logic              iCLK = 1'b0;
    logic              iRST = 1'b1;
    logic [NREQ-1:0]   iReq = '0;
    logic [NREQ-1:0]   iLock = '0;
    logic [9*NREQ-1:0] iCmd = '0;
    logic              iLCD_Done = 1'b0;
    logic [NREQ-1:0]   oAck, oGrant;
    logic              oBusy, oErr, oLCD_RS, oLCD_Start;
    logic [7:0]        oLCD_DATA;

    int n_checks = 0;
    int n_errors = 0;

    word_t drv_q[NREQ][$];
    word_t model_q[NREQ][$];
    exp_t  exp_q[$];
    int    lat_q[$];
    int    m_ptr = 0;
    logic  m_lock = 1'b0;
    int    m_owner = 0;
    int    mon_phase = 0;

    always #5 iCLK = ~iCLK;

    lcd_cmd_arbiter #(
        .NREQ(NREQ), .DLY_W(20), .DLY_SHORT(DLY_SHORT), .DLY_LONG(DLY_LONG), .DONE_TMO(DONE_TMO)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iLock(iLock), .iCmd(iCmd),
        .oAck(oAck), .oGrant(oGrant), .oBusy(oBusy), .oErr(oErr),
        .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS), .oLCD_Start(oLCD_Start), .iLCD_Done(iLCD_Done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_long(input logic [8:0] c);
        return (c[8] == 1'b0) && (c[7:0] >= 8'd1) && (c[7:0] <= 8'd3);
    endfunction

    task automatic add_word(input int r, input logic [8:0] cmd, input logic lock, input int lat);
        word_t w;
        w.cmd  = cmd;
        w.lock = lock;
        w.lat  = lat;
        drv_q[r].push_back(w);
        model_q[r].push_back(w);
    endtask

    // Reference: serve pending words round-robin from the pointer; a lock pins the owner.
    task automatic model_run();
        int    w, c;
        word_t wd;
        exp_t  e;
        forever begin
            w = -1;
            if (m_lock) begin
                if (model_q[m_owner].size() > 0) w = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (w < 0 && model_q[c].size() > 0) w = c;
                end
            end
            if (w < 0) break;
            wd           = model_q[w].pop_front();
            e.idx        = w;
            e.cmd        = wd.cmd;
            e.err        = (wd.lat < 0);
            e.lat        = wd.lat;
            e.settle     = is_long(wd.cmd) ? DLY_LONG : DLY_SHORT;
            e.lock_after = !e.err && wd.lock;
            exp_q.push_back(e);
            lat_q.push_back(wd.lat);
            m_ptr   = (w + 1) % NREQ;
            m_lock  = e.lock_after;
            m_owner = w;
        end
    endtask

    task automatic do_reset();
        @(posedge iCLK);
        #1 iRST = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            drv_q[r].delete();
            model_q[r].delete();
        end
        exp_q.delete();
        lat_q.delete();
        m_ptr   = 0;
        m_lock  = 1'b0;
        m_owner = 0;
        @(posedge iCLK);
        #1 iRST = 1'b0;
        @(negedge iCLK);
        check("reset_outputs", {oAck, oGrant, oBusy, oErr, oLCD_RS, oLCD_DATA, oLCD_Start}, 0);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_phase != 0 || oBusy) && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        if (n >= budget) check("drain_timeout", exp_q.size(), 0);
        @(negedge iCLK);
    endtask

    // Requester agents: present queue head, advance on ack.
    initial begin
        forever begin
            @(posedge iCLK);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (oAck[i] && drv_q[i].size() > 0) drv_q[i].delete(0);
                iReq[i] = (drv_q[i].size() > 0);
                if (iReq[i]) begin
                    iCmd[9*i +: 9] = drv_q[i][0].cmd;
                    iLock[i]       = drv_q[i][0].lock;
                end else begin
                    iLock[i] = 1'b0;
                end
            end
        end
    end

    // LCD_Core model: Done high during the lat-th cycle after Start first seen.
    initial begin
        int lat, guard;
        forever begin
            @(negedge iCLK);
            if (oLCD_Start && !iRST) begin
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
                if (lat > 0) begin
                    repeat (lat - 1) @(negedge iCLK);
                    @(posedge iCLK);
                    #1 iLCD_Done = 1'b1;
                    @(posedge iCLK);
                    #1 iLCD_Done = 1'b0;
                end
                guard = 0;
                while (oLCD_Start && guard < 100) begin
                    @(negedge iCLK);
                    guard++;
                end
            end
        end
    end

    // Monitor: pops one expectation per ack and follows the transaction to its end.
    initial begin
        exp_t cur;
        int   start_cnt, settle_cnt;
        cur = '0;
        start_cnt = 0;
        settle_cnt = 0;
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                mon_phase = 0;
            end else begin
                case (mon_phase)
                    0: begin
                        if (oAck != '0) begin
                            if (exp_q.size() == 0) begin
                                check("unexpected_ack", oAck, 0);
                            end else begin
                                cur = exp_q.pop_front();
                                check("ack_onehot", oAck, 1 << cur.idx);
                                check("grant_at_ack", oGrant, 1 << cur.idx);
                                check("word_latched", {oLCD_RS, oLCD_DATA}, cur.cmd);
                                check("start_with_ack", oLCD_Start, 1);
                                start_cnt = 1;
                                mon_phase = 1;
                            end
                        end else begin
                            check("idle_no_err", oErr, 0);
                            check("idle_not_busy", oBusy, 0);
                        end
                    end
                    1: begin
                        if (oLCD_Start) begin
                            start_cnt++;
                            if (start_cnt > DONE_TMO + 4) begin
                                check("start_stuck", start_cnt, DONE_TMO + 1);
                                mon_phase = 0;
                            end
                        end else begin
                            check("start_len", start_cnt, cur.err ? DONE_TMO + 1 : cur.lat + 1);
                            check("err_pulse", oErr, cur.err);
                            if (cur.err) begin
                                check("err_idle_grant", {oBusy, oGrant}, 0);
                                mon_phase = 0;
                            end else begin
                                check("settle_busy", oBusy, 1);
                                settle_cnt = 1;
                                mon_phase  = 2;
                            end
                        end
                    end
                    default: begin
                        if (oBusy) begin
                            settle_cnt++;
                            check("word_stable", {oLCD_Start, oLCD_RS, oLCD_DATA}, {1'b0, cur.cmd});
                            if (settle_cnt > DLY_LONG + 4) begin
                                check("settle_stuck", settle_cnt, cur.settle);
                                mon_phase = 0;
                            end
                        end else begin
                            check("settle_len", settle_cnt, cur.settle);
                            check("grant_after", oGrant, cur.lock_after ? (1 << cur.idx) : 0);
                            mon_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: time budget exhausted, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] cmd;
        int         n, lat;
        repeat (2) @(posedge iCLK);
        do_reset();

        // Single character, Done after 4 cycles.
        add_word(0, 9'h131, 1'b0, 4);
        model_run();
        wait_drain(500);

        // Fresh pointer: 0,1,2 then req0's second word.
        do_reset();
        add_word(0, 9'h141, 1'b0, 2);
        add_word(1, 9'h142, 1'b0, 3);
        add_word(2, 9'h143, 1'b0, 5);
        add_word(0, 9'h144, 1'b0, 1);
        model_run();
        wait_drain(1000);

        // Locked burst from req1 while req2 waits.
        add_word(1, 9'h151, 1'b1, 2);
        add_word(1, 9'h152, 1'b1, 3);
        add_word(1, 9'h153, 1'b1, 1);
        add_word(1, 9'h154, 1'b0, 2);
        add_word(2, 9'h15F, 1'b0, 2);
        model_run();
        wait_drain(1000);

        // Long vs short settle.
        add_word(0, lcd_pkg::LCD_CLEAR, 1'b0, 3);
        add_word(0, lcd_pkg::LCD_LINE2, 1'b0, 3);
        add_word(0, lcd_pkg::LCD_HOME, 1'b0, 3);
        model_run();
        wait_drain(1000);

        // Timeout on a locked word clears the lock; Done on the last wait cycle is not an error.
        add_word(1, 9'h161, 1'b1, -1);
        add_word(1, 9'h162, 1'b0, 2);
        add_word(2, 9'h163, 1'b0, 2);
        add_word(0, 9'h164, 1'b0, DONE_TMO);
        model_run();
        wait_drain(1000);

        // Lock held with owner idle: others must wait.
        add_word(1, 9'h171, 1'b1, 3);
        model_run();
        wait_drain(500);
        add_word(2, 9'h172, 1'b0, 3);
        model_run();
        repeat (40) @(negedge iCLK);
        check("stall_not_busy", oBusy, 0);
        check("stall_grant_owner", oGrant, 3'b010);
        add_word(1, 9'h173, 1'b0, 2);
        model_run();
        wait_drain(1000);

        // Randomised rounds.
        for (int round = 0; round < 12; round++) begin
            for (int r = 0; r < NREQ; r++) begin
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin
                    case ($urandom_range(0, 5))
                        0: cmd = lcd_pkg::LCD_CLEAR;
                        1: cmd = lcd_pkg::LCD_HOME;
                        2: cmd = 9'h003;
                        3: cmd = lcd_pkg::LCD_LINE2;
                        4: cmd = 9'h004 + 9'($urandom_range(0, 8));
                        default: cmd = {1'b1, 8'($urandom_range(0, 255))};
                    endcase
                    lat = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, DONE_TMO);
                    add_word(r, cmd, (k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0, lat);
                end
            end
            model_run();
            wait_drain(4000);
        end

        // Reset during WAIT_DONE aborts silently; pointer restarts at requester 0.
        add_word(2, 9'h181, 1'b0, -1);
        model_run();
        repeat (6) @(negedge iCLK);
        check("in_wait_done", {oBusy, oLCD_Start}, 2'b11);
        do_reset();
        repeat (30) @(negedge iCLK);
        add_word(2, 9'h192, 1'b0, 2);
        add_word(1, 9'h191, 1'b0, 2);
        model_run();
        wait_drain(1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
